// File: rtl/division_dispatcher.sv
// -----------------------------------------------------------------------------
// division_dispatcher
//
// Front-end for the slow_division1 divider. Operand pairs arrive on a
// valid/ready input and are buffered in a small FIFO. One divide runs at a
// time: the dispatcher pops an entry, holds Nr/Dr on div_nr/div_dr, pulses
// div_start for one cycle and waits for a rising edge on div_done (or a
// timeout). The quotient/remainder land in a single output register that is
// drained with valid/ready.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   defined   : entries with Dr==0 never reach the divider; an error result
//               (Q=all ones, R=Nr, err=1) is produced the cycle after the pop.
//   undefined : Dr==0 is dispatched like any other operand pair.
//
// Parameters
//   WIDTH        operand/result width
//   DEPTH        operand FIFO entries (power of 2, >=2)
//   TIMEOUT_CYC  maximum WAIT cycles before the divide is abandoned (>=2)
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid/in_ready     operand handshake, in_ready = FIFO not full
//   in_nr, in_dr          dividend / divisor
//   div_start             one-cycle start pulse to the divider
//   div_nr, div_dr        operands to the divider, held from pop to next pop
//   div_done, div_q/r     divider completion flag and results
//   out_valid/out_ready   result handshake
//   out_q, out_r, out_err result and error flag (timeout / divide-by-zero)
//   busy                  FSM is not idle
//   level                 FIFO occupancy
// -----------------------------------------------------------------------------
module division_dispatcher #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_nr,
  input  logic [WIDTH-1:0]         in_dr,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_nr,
  output logic [WIDTH-1:0]         div_dr,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_q,
  input  logic [WIDTH-1:0]         div_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_q,
  output logic [WIDTH-1:0]         out_r,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] r_memNr [DEPTH];
  logic [WIDTH-1:0] r_memDr [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_level;

  // Divider-side registers
  logic [WIDTH-1:0] r_divNr;
  logic [WIDTH-1:0] r_divDr;
  logic             r_doneQ;
  logic [CW-1:0]    r_cnt;

  // Output slot
  logic             r_outValid;
  logic [WIDTH-1:0] r_outQ;
  logic [WIDTH-1:0] r_outR;
  logic             r_outErr;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_outFree;
  logic [WIDTH-1:0] w_headNr;
  logic [WIDTH-1:0] w_headDr;
  logic             w_bypass;
  logic             w_bypassLoad;
  logic             w_complete;
  logic             w_timeout;

  // Full blocks pushes even if a pop happens in the same cycle, which keeps
  // in_ready a pure function of registered state.
  assign w_full   = (r_level == (AW+1)'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_push   = in_valid && !w_full;
  assign in_ready = !w_full;
  assign level    = r_level;

  assign w_headNr = r_memNr[r_rdPtr];
  assign w_headDr = r_memDr[r_rdPtr];

  // The output slot counts as free when it is empty or draining this cycle,
  // so a new result can load on the same edge the old one leaves.
  assign w_outFree = !r_outValid || out_ready;

  // Pop only from IDLE: this guarantees a single divide in flight and that
  // the output slot is reserved for the popped entry's result.
  assign w_pop = (r_state == ST_IDLE) && !w_empty && w_outFree;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_bypass = (w_headDr == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_bypassLoad = w_pop && w_bypass;

  // Completion is the rising edge of div_done, so a done flag the divider
  // still holds from the previous operation is not mistaken for this one.
  assign w_complete = (r_state == ST_WAIT) && div_done && !r_doneQ;
  assign w_timeout  = (r_state == ST_WAIT) && !w_complete &&
                      (r_cnt == CW'(TIMEOUT_CYC - 1));

  // FIFO storage is written without reset; only pointers/level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memNr[r_wrPtr] <= in_nr;
      r_memDr[r_wrPtr] <= in_dr;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop && !w_bypass) begin
          w_nextState = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_complete || w_timeout) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    div_start = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_LAUNCH: begin
        div_start = 1'b1;
        busy      = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      default: begin
        div_start = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Operands are captured at pop and held until the next pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divNr <= '0;
      r_divDr <= '0;
    end else if (w_pop) begin
      r_divNr <= w_headNr;
      r_divDr <= w_headDr;
    end
  end

  assign div_nr = r_divNr;
  assign div_dr = r_divDr;

  // Delayed div_done for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_doneQ <= 1'b0;
    end else begin
      r_doneQ <= div_done;
    end
  end

  // Timeout counter: cleared in LAUNCH, counts WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !w_complete && !w_timeout) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Output register. Loads never collide with a pending result because the
  // slot was reserved at pop time; out_q/out_r are left untouched on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outQ     <= '0;
      r_outR     <= '0;
      r_outErr   <= 1'b0;
    end else if (w_complete) begin
      r_outValid <= 1'b1;
      r_outQ     <= div_q;
      r_outR     <= div_r;
      r_outErr   <= 1'b0;
    end else if (w_timeout) begin
      r_outValid <= 1'b1;
      r_outQ     <= '0;
      r_outR     <= '0;
      r_outErr   <= 1'b1;
    end else if (w_bypassLoad) begin
      r_outValid <= 1'b1;
      r_outQ     <= {WIDTH{1'b1}};
      r_outR     <= w_headNr;
      r_outErr   <= 1'b1;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_q     = r_outQ;
  assign out_r     = r_outR;
  assign out_err   = r_outErr;

endmodule

// File: tb/tb_division_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_division_dispatcher
//
// Directed bench for division_dispatcher with a behavioural divider stub.
// The stub answers a start pulse after a few cycles with Nr/Dr (Dr==0 gives
// Q=all ones, R=Nr) and holds done until the next start; stubHang suppresses
// done to provoke the timeout path.
// -----------------------------------------------------------------------------
module tb_division_dispatcher;

  localparam int WIDTH       = 4;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 32;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_nr;
  logic [WIDTH-1:0]       in_dr;
  logic                   div_start;
  logic [WIDTH-1:0]       div_nr;
  logic [WIDTH-1:0]       div_dr;
  logic                   div_done;
  logic [WIDTH-1:0]       div_q;
  logic [WIDTH-1:0]       div_r;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_q;
  logic [WIDTH-1:0]       out_r;
  logic                   out_err;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;

  int vectors     = 0;
  int miscompares = 0;
  int startCount  = 0;
  int waitCycles  = 0;
  int startBase;
  logic stubHang;
  int stubCnt;
  logic [2*WIDTH:0] resQ [$];
  logic [2*WIDTH:0] res;

  division_dispatcher #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_nr(in_nr), .in_dr(in_dr),
    .div_start(div_start), .div_nr(div_nr), .div_dr(div_dr),
    .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_err(out_err),
    .busy(busy), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stub: three cycles from sampled start to done.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_done <= 1'b0;
      div_q    <= '0;
      div_r    <= '0;
      stubCnt  <= 0;
    end else if (div_start) begin
      div_done <= 1'b0;
      stubCnt  <= 3;
    end else if (stubCnt != 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == 1 && !stubHang) begin
        div_done <= 1'b1;
        if (div_dr == '0) begin
          div_q <= {WIDTH{1'b1}};
          div_r <= div_nr;
        end else begin
          div_q <= div_nr / div_dr;
          div_r <= div_nr % div_dr;
        end
      end
    end
  end

  // Monitor on the falling edge: accepted results, start pulses, WAIT cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) resQ.push_back({out_err, out_q, out_r});
      if (div_start) startCount++;
      if (busy && !div_start) waitCycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one operand pair and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [WIDTH-1:0] nr, input logic [WIDTH-1:0] dr);
    logic acc;
    int tries;
    in_valid = 1'b1;
    in_nr    = nr;
    in_dr    = dr;
    tries    = 0;
    acc      = 1'b0;
    while (!acc && tries < 200) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic waitResults(input int n);
    int cyc;
    cyc = 0;
    while (resQ.size() < n && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("result_count", 32'(resQ.size()), 32'(n));
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] q,
                             input logic [WIDTH-1:0] r, input logic err);
    if (resQ.size() == 0) begin
      checkOutput({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      res = resQ.pop_front();
      checkOutput({tag, "_q"},   32'(res[2*WIDTH-1:WIDTH]), 32'(q));
      checkOutput({tag, "_r"},   32'(res[WIDTH-1:0]),       32'(r));
      checkOutput({tag, "_err"}, 32'(res[2*WIDTH]),         32'(err));
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_nr     = '0;
    in_dr     = '0;
    out_ready = 1'b1;
    stubHang  = 1'b0;
    tick(3);

    // Reset state
    checkOutput("rst_level",     32'(level),     32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_div_start", 32'(div_start), 32'd0);
    checkOutput("rst_div_nr",    32'(div_nr),    32'd0);
    checkOutput("rst_out_q",     32'(out_q),     32'd0);
    checkOutput("rst_out_err",   32'(out_err),   32'd0);
    reset = 1'b0;
    tick(2);

    // 1: single 7/2 with latency checks
    $display("[TB] test 1: single divide");
    startBase = startCount;
    applyStimulus(4'd7, 4'd2);
    checkOutput("t1_level_after_push", 32'(level),     32'd1);
    checkOutput("t1_no_start_yet",     32'(div_start), 32'd0);
    tick(1);
    checkOutput("t1_start_pulse", 32'(div_start), 32'd1);
    checkOutput("t1_div_nr",      32'(div_nr),    32'd7);
    checkOutput("t1_div_dr",      32'(div_dr),    32'd2);
    checkOutput("t1_busy",        32'(busy),      32'd1);
    checkOutput("t1_level_popped",32'(level),     32'd0);
    tick(1);
    checkOutput("t1_start_one_cycle", 32'(div_start), 32'd0);
    waitResults(1);
    checkResult("t1", 4'd3, 4'd1, 1'b0);
    checkOutput("t1_start_count", 32'(startCount - startBase), 32'd1);

    // 2: back-to-back pushes
    $display("[TB] test 2: back-to-back");
    tick(2);
    startBase = startCount;
    applyStimulus(4'd7, 4'd2);
    applyStimulus(4'd14, 4'd5);
    waitResults(2);
    checkResult("t2a", 4'd3, 4'd1, 1'b0);
    checkResult("t2b", 4'd2, 4'd4, 1'b0);
    tick(3);
    checkOutput("t2_start_count", 32'(startCount - startBase), 32'd2);

    // 3: backpressure with five entries
    $display("[TB] test 3: backpressure");
    out_ready = 1'b0;
    startBase = startCount;
    applyStimulus(4'd15, 4'd4);
    applyStimulus(4'd8,  4'd3);
    applyStimulus(4'd9,  4'd2);
    applyStimulus(4'd13, 4'd6);
    applyStimulus(4'd12, 4'd7);
    checkOutput("t3_level_full", 32'(level),    32'd4);
    checkOutput("t3_not_ready",  32'(in_ready), 32'd0);
    tick(20);
    checkOutput("t3_held_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_held_q",     32'(out_q),     32'd3);
    checkOutput("t3_held_r",     32'(out_r),     32'd3);
    checkOutput("t3_one_start",  32'(startCount - startBase), 32'd1);
    checkOutput("t3_still_full", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    waitResults(5);
    checkResult("t3a", 4'd3, 4'd3, 1'b0);
    checkResult("t3b", 4'd2, 4'd2, 1'b0);
    checkResult("t3c", 4'd4, 4'd1, 1'b0);
    checkResult("t3d", 4'd2, 4'd1, 1'b0);
    checkResult("t3e", 4'd1, 4'd5, 1'b0);
    checkOutput("t3_start_count", 32'(startCount - startBase), 32'd5);

    // 4: divide by zero
    $display("[TB] test 4: divide by zero");
    tick(2);
    startBase = startCount;
    applyStimulus(4'd9, 4'd0);
    waitResults(1);
`ifdef DIV_ZERO_BYPASS_EN
    checkResult("t4", 4'd15, 4'd9, 1'b1);
    checkOutput("t4_start_count", 32'(startCount - startBase), 32'd0);
`else
    checkResult("t4", 4'd15, 4'd9, 1'b0);
    checkOutput("t4_start_count", 32'(startCount - startBase), 32'd1);
`endif

    // 5: timeout
    $display("[TB] test 5: timeout");
    tick(2);
    stubHang   = 1'b1;
    waitCycles = 0;
    applyStimulus(4'd7, 4'd2);
    waitResults(1);
    checkResult("t5", 4'd0, 4'd0, 1'b1);
    checkOutput("t5_wait_cycles", 32'(waitCycles), 32'(TIMEOUT_CYC));

    // 6: reset during WAIT with queued entries
    $display("[TB] test 6: reset mid-operation");
    tick(2);
    applyStimulus(4'd7, 4'd2);
    applyStimulus(4'd8, 4'd3);
    applyStimulus(4'd9, 4'd4);
    tick(3);
    checkOutput("t6_level_queued", 32'(level), 32'd2);
    checkOutput("t6_busy_wait",    32'(busy),  32'd1);
    startBase = startCount;
    reset = 1'b1;
    #2;
    checkOutput("t6_rst_level",     32'(level),     32'd0);
    checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_busy",      32'(busy),      32'd0);
    tick(1);
    reset    = 1'b0;
    stubHang = 1'b0;
    tick(20);
    checkOutput("t6_no_start",   32'(startCount - startBase), 32'd0);
    checkOutput("t6_level_post", 32'(level),       32'd0);
    checkOutput("t6_no_result",  32'(resQ.size()), 32'd0);
    checkOutput("t6_out_valid",  32'(out_valid),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
